// File: rtl/error_monitor.sv
// rtl/error_monitor.sv - valid-qualified masked pattern error monitor with saturating count, sticky flag and alarm FSM
// Optional X/Z sample detection (simulation only) enabled by defining ERRMON_XZ_CHECK_EN.
module error_monitor #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8,
  parameter int THRESH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_valid,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [WIDTH-1:0]     cfg_pattern,
  input  logic [WIDTH-1:0]     cfg_mask,
  input  logic                 clr,
  output logic                 error_flag,
  output logic                 sticky_error,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 alarm,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    S_OK      = 2'd0,
    S_SUSPECT = 2'd1,
    S_ALARM   = 2'd2
  } state_t;

  localparam logic [7:0] THRESH_L = 8'(THRESH);

  state_t     cur_state, next_state;
  logic [7:0] run, next_run;
  logic       pattern_hit;
  logic       hit;

  assign pattern_hit = (cfg_mask != '0) && (((data_in ^ cfg_pattern) & cfg_mask) == '0);

`ifdef ERRMON_XZ_CHECK_EN
  logic xz_hit;
  assign xz_hit = ((^data_in) === 1'bx);
  assign hit    = data_valid && (pattern_hit || xz_hit);
`else
  assign hit    = data_valid && pattern_hit;
`endif

  // Run length only counts valid samples; idle cycles leave it untouched.
  always_comb begin
    next_state = cur_state;
    next_run   = run;
    if (clr) begin
      next_state = S_OK;
      next_run   = 8'd0;
    end else begin
      case (cur_state)
        S_OK: begin
          if (hit) begin
            next_run   = 8'd1;
            next_state = (THRESH_L == 8'd1) ? S_ALARM : S_SUSPECT;
          end else if (data_valid) begin
            next_run = 8'd0;
          end
        end
        S_SUSPECT: begin
          if (hit) begin
            next_run = run + 8'd1;
            if (run + 8'd1 == THRESH_L) next_state = S_ALARM;
          end else if (data_valid) begin
            next_run   = 8'd0;
            next_state = S_OK;
          end
        end
        S_ALARM: next_state = S_ALARM;
        default: begin
          next_state = S_OK;
          next_run   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_OK;
      run       <= 8'd0;
    end else begin
      cur_state <= next_state;
      run       <= next_run;
    end
  end

  // clr wins over a coincident hit for count/sticky, but error_flag still reports it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_flag   <= 1'b0;
      sticky_error <= 1'b0;
      err_count    <= '0;
    end else begin
      error_flag <= hit;
      if (clr) begin
        sticky_error <= 1'b0;
        err_count    <= '0;
      end else if (hit) begin
        sticky_error <= 1'b1;
        if (err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
      end
    end
  end

  assign alarm = (cur_state == S_ALARM);
  assign state = cur_state;

endmodule
